// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin owner selection for the shared SyncFIFO read port.
// Eight read channels compete for the port. The winner's one-hot select drives the read mux.
// Each grant runs the sequence IDLE -> GRANT -> RELEASE -> IDLE, so two grants are always
// separated by at least two cycles. All outputs are registered.
// Optional feature: define RD_ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles
// when another channel is waiting. The default build has no hold counter and ties o_timeout low.
module fifo_rd_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  input  logic       i_busy,
  output logic [7:0] o_select,
  output logic       o_grant_vld,
  output logic [2:0] o_grant_idx,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  state_e     r_state;
  logic [7:0] r_select;
  logic       r_grant_vld;
  logic [2:0] r_grant_idx;
  logic       r_timeout;
  logic [2:0] r_ptr;

  logic [2:0] w_winner;
  logic [7:0] w_winner_oh;
  logic       w_any_req;
  logic       w_owner_req;
  logic       w_others_req;

  assign w_any_req    = |i_req;
  assign w_owner_req  = i_req[r_grant_idx];
  // Requesters other than the current owner; only used to decide a forced release.
  assign w_others_req = |(i_req & ~r_select);
  assign w_winner_oh  = 8'd1 << w_winner;

  // Rotating priority search: first set request at or after ptr+1, wrapping through ptr itself.
  always_comb begin
    logic       v_found;
    logic [2:0] v_cand;
    v_found  = 1'b0;
    v_cand   = 3'd0;
    w_winner = r_ptr;
    for (int k = 1; k <= 8; k++) begin
      v_cand = r_ptr + 3'(k);
      if (!v_found && i_req[v_cand]) begin
        w_winner = v_cand;
        v_found  = 1'b1;
      end
    end
  end

`ifdef RD_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              w_hold_last;
  logic              w_force_rel;

  assign w_hold_last = (r_hold == HOLD_LAST);
  assign w_force_rel = w_hold_last && w_others_req;
`else
  // Without the timeout feature the hold parameters and the other-requester term are unused.
  logic [64:0] w_unused_cfg;
  assign w_unused_cfg = {MAX_HOLD, HOLD_W, w_others_req};
`endif

  // Arbitration FSM; all outputs are updated on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_select    <= 8'b0000_0001;
      r_grant_vld <= 1'b0;
      r_grant_idx <= 3'd0;
      r_timeout   <= 1'b0;
      r_ptr       <= 3'd7;
`ifdef RD_ARB_TIMEOUT_EN
      r_hold      <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          // select keeps its last value while idle so the mux input does not move.
          if (w_any_req && !i_busy) begin
            r_state     <= StGrant;
            r_select    <= w_winner_oh;
            r_grant_idx <= w_winner;
            r_grant_vld <= 1'b1;
            r_ptr       <= w_winner;
`ifdef RD_ARB_TIMEOUT_EN
            r_hold      <= '0;
`endif
          end
        end
        StGrant: begin
          // busy never preempts an owner; only its own req drop (or a timeout) ends the grant.
          if (!w_owner_req) begin
            r_state     <= StRelease;
            r_grant_vld <= 1'b0;
          end
`ifdef RD_ARB_TIMEOUT_EN
          else if (w_force_rel) begin
            r_state     <= StRelease;
            r_grant_vld <= 1'b0;
            r_timeout   <= 1'b1;
          end else if (!w_hold_last) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
`endif
        end
        StRelease: begin
          r_state <= StIdle;
        end
        default: begin
          r_state     <= StIdle;
          r_grant_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_select    = r_select;
  assign o_grant_vld = r_grant_vld;
  assign o_grant_idx = r_grant_idx;
  assign o_timeout   = r_timeout;

  // Structural invariants of the select output.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($onehot(r_select));
      assert (r_select == (8'd1 << r_grant_idx));
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed scenarios plus a randomized run.
// The reference is an event-level model of the arbitration rules.
module tb_fifo_rd_arbiter;

  localparam int unsigned MaxHold = 16;

  logic       clk;
  logic       i_rst;
  logic [7:0] i_req;
  logic       i_busy;
  logic [7:0] o_select;
  logic       o_grant_vld;
  logic [2:0] o_grant_idx;
  logic       o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model. Phase values: 0 = idle, 1 = granted, 2 = releasing.
  int   m_phase = 0;
  int   m_own   = 0;
  int   m_ptr   = 7;
  int   m_hold  = 0;
  logic m_vld   = 1'b0;
  logic m_to    = 1'b0;

`ifdef RD_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  fifo_rd_arbiter #(
    .MAX_HOLD(MaxHold),
    .HOLD_W  (5)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_busy     (i_busy),
    .o_select   (o_select),
    .o_grant_vld(o_grant_vld),
    .o_grant_idx(o_grant_idx),
    .o_timeout  (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1);
  end

  // Apply the rules to one clock edge, using the inputs present at that edge.
  task automatic model_step();
    m_to = 1'b0;
    if (i_rst) begin
      m_phase = 0; m_own = 0; m_ptr = 7; m_hold = 0; m_vld = 1'b0;
    end else if (m_phase == 0) begin
      if (i_req != 8'h00 && !i_busy) begin
        for (int k = 1; k <= 8; k++) begin
          if (i_req[(m_ptr + k) % 8]) begin
            m_own = (m_ptr + k) % 8;
            break;
          end
        end
        m_ptr = m_own; m_phase = 1; m_vld = 1'b1; m_hold = 1;
      end
    end else if (m_phase == 1) begin
      // m_hold counts grant cycles already completed, including the one ending now.
      if (!i_req[m_own]) begin
        m_phase = 2; m_vld = 1'b0;
      end else if (TimeoutOn && m_hold >= MaxHold &&
                   (i_req & ~(8'd1 << m_own)) != 8'h00) begin
        m_phase = 2; m_vld = 1'b0; m_to = 1'b1;
      end else begin
        m_hold = m_hold + 1;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cycle(input logic [7:0] req, input logic busy, input logic rst_in);
    @(negedge clk);
    i_req  = req;
    i_busy = busy;
    i_rst  = rst_in;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cycle(8'hFF, 1'b0, 1'b1);
    cycle(8'hFF, 1'b0, 1'b1);
    n_checks++;
    if (o_select !== 8'h01 || o_grant_vld !== 1'b0 || o_grant_idx !== 3'd0 || o_timeout !== 1'b0)
    begin
      n_fail++;
      $display("FAIL reset: sel=%h vld=%b idx=%0d to=%b, want 01/0/0/0",
               o_select, o_grant_vld, o_grant_idx, o_timeout);
    end
  endtask

  task automatic test_single();
    cycle(8'h08, 1'b0, 1'b0);
    n_checks++;
    if (o_select !== 8'h08 || o_grant_idx !== 3'd3 || o_grant_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: sel=%h idx=%0d vld=%b, want 08/3/1",
               o_select, o_grant_idx, o_grant_vld);
    end
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    n_checks++;
    if (o_grant_vld !== 1'b0 || o_select !== 8'h08) begin
      n_fail++;
      $display("FAIL single_release: vld=%b sel=%h, want 0/08", o_grant_vld, o_select);
    end
    // Request again during release: must not be granted before a full idle cycle.
    cycle(8'h08, 1'b0, 1'b0);
    n_checks++;
    if (o_grant_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: vld=%b, want 0", o_grant_vld);
    end
    cycle(8'h08, 1'b0, 1'b0);
    n_checks++;
    if (o_grant_vld !== 1'b1 || o_grant_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL single_regrant: vld=%b idx=%0d, want 1/3", o_grant_vld, o_grant_idx);
    end
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 7, 0, 7};
    cycle(8'h81, 1'b0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      cycle(8'h81, 1'b0, 1'b0);
      n_checks++;
      if (o_grant_vld !== 1'b1 || o_grant_idx !== 3'(exp_order[g])) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: vld=%b idx=%0d, want 1/%0d",
                 g, o_grant_vld, o_grant_idx, exp_order[g]);
      end
      cycle(8'h81 & ~(8'd1 << exp_order[g]), 1'b0, 1'b0);
      cycle(8'h81, 1'b0, 1'b0);
    end
    cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_busy();
    cycle(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h04, 1'b1, 1'b0);
      n_checks++;
      if (o_grant_vld !== 1'b0 || o_select !== 8'h01) begin
        n_fail++;
        $display("FAIL busy_idle[%0d]: vld=%b sel=%h, want 0/01", i, o_grant_vld, o_select);
      end
    end
    cycle(8'h04, 1'b0, 1'b0);
    n_checks++;
    if (o_grant_vld !== 1'b1 || o_select !== 8'h04) begin
      n_fail++;
      $display("FAIL busy_clear: vld=%b sel=%h, want 1/04", o_grant_vld, o_select);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(8'h04, 1'b1, 1'b0);
      n_checks++;
      if (o_grant_vld !== 1'b1 || o_select !== 8'h04) begin
        n_fail++;
        $display("FAIL busy_grant[%0d]: vld=%b sel=%h, want 1/04", i, o_grant_vld, o_select);
      end
    end
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int held = 0;
    int pulses = 0;
    int ch2_at = -1;
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h02, 1'b0, 1'b0);
    if (o_grant_vld === 1'b1 && o_grant_idx === 3'd1) held++;
    for (int i = 1; i <= 20; i++) begin
      cycle(8'h06, 1'b0, 1'b0);
      if (o_grant_vld === 1'b1 && o_grant_idx === 3'd1) held++;
      if (o_timeout === 1'b1) pulses++;
      if (o_grant_vld === 1'b1 && o_grant_idx === 3'd2 && ch2_at < 0) ch2_at = i;
    end
    n_checks++;
    if (held != (TimeoutOn ? 16 : 21)) begin
      n_fail++;
      $display("FAIL timeout_hold: ch1 grant cycles=%0d, want %0d", held, TimeoutOn ? 16 : 21);
    end
    n_checks++;
    if (pulses != (TimeoutOn ? 1 : 0)) begin
      n_fail++;
      $display("FAIL timeout_pulse: pulses=%0d, want %0d", pulses, TimeoutOn ? 1 : 0);
    end
    n_checks++;
    if (ch2_at != (TimeoutOn ? 18 : -1)) begin
      n_fail++;
      $display("FAIL timeout_next: ch2 granted at %0d, want %0d", ch2_at, TimeoutOn ? 18 : -1);
    end
    // A lone owner is never forced off, whatever the build.
    cycle(8'h00, 1'b0, 1'b1);
    held = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(8'h02, 1'b0, 1'b0);
      if (o_grant_vld === 1'b1) held++;
      if (o_timeout === 1'b1) pulses++;
    end
    n_checks++;
    if (held != 30 || pulses != 0) begin
      n_fail++;
      $display("FAIL timeout_alone: grant cycles=%0d pulses=%0d, want 30/0", held, pulses);
    end
  endtask

  task automatic test_reset_mid_grant();
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h20, 1'b0, 1'b0);
    cycle(8'h20, 1'b0, 1'b0);
    cycle(8'h20, 1'b0, 1'b1);
    n_checks++;
    if (o_select !== 8'h01 || o_grant_vld !== 1'b0 || o_grant_idx !== 3'd0 ||
        o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: sel=%h vld=%b idx=%0d to=%b, want 01/0/0/0",
               o_select, o_grant_vld, o_grant_idx, o_timeout);
    end
    // Reset lands in IDLE directly, so a held request is granted on the very next edge.
    cycle(8'h20, 1'b0, 1'b0);
    n_checks++;
    if (o_grant_vld !== 1'b1 || o_select !== 8'h20 || o_grant_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: vld=%b sel=%h idx=%0d, want 1/20/5",
               o_grant_vld, o_select, o_grant_idx);
    end
  endtask

  task automatic test_random();
    logic [7:0] req = 8'h00;
    logic       busy;
    logic       rst_in;
    logic [7:0] e_sel;
    int         errs = 0;
    cycle(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      // First half changes requests often; second half keeps them stable to reach timeouts.
      if (i < 400 || $urandom_range(0, 7) == 0) req = 8'($urandom) & 8'($urandom);
      busy   = ($urandom_range(0, 3) == 0);
      rst_in = ($urandom_range(0, 99) == 0);
      cycle(req, busy, rst_in);
      e_sel = 8'd1 << m_own;
      n_checks++;
      if (o_select !== e_sel || o_grant_vld !== m_vld || o_grant_idx !== 3'(m_own) ||
          o_timeout !== m_to) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: sel=%h vld=%b idx=%0d to=%b, want %h/%b/%0d/%b",
                   i, o_select, o_grant_vld, o_grant_idx, o_timeout,
                   e_sel, m_vld, m_own, m_to);
      end
    end
  endtask

  initial begin
    i_rst  = 1'b1;
    i_req  = 8'h00;
    i_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
